// File: rtl/sparse_mask_walk_scheduler_if.sv
// Bitmask-in / beat-out handshake bundle for sparse_mask_walk_scheduler.
// slave = scheduler side, master = producer/consumer side.
interface sparse_mask_walk_scheduler_if #(
  parameter int MASK_WIDTH = 8,
  parameter int IDX_WIDTH  = 4,
  parameter int TAG_WIDTH  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [MASK_WIDTH-1:0] in_mask;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [IDX_WIDTH-1:0]  out_index;
  logic [IDX_WIDTH-1:0]  out_zero_run;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  out_last;
  logic                  out_empty;

  modport slave (
    input  in_valid, in_mask, in_tag, out_ready,
    output in_ready, out_valid, out_index,
    output out_zero_run, out_tag, out_last,
    output out_empty
  );

  modport master (
    output in_valid, in_mask, in_tag, out_ready,
    input  in_ready, out_valid, out_index,
    input  out_zero_run, out_tag, out_last,
    input  out_empty
  );
endinterface

// File: rtl/sparse_mask_walk_scheduler.sv
// Walks a sparse-weight bitmask LSB first, one beat per set bit.
// SPARSE_MASK_WALK_B2B_EN: accept next mask alongside the final beat.
module sparse_mask_walk_scheduler #(
  parameter int MASK_WIDTH = 8,
  parameter int IDX_WIDTH  = 4,
  parameter int TAG_WIDTH  = 8
) (
  input  logic i_clock,
  input  logic i_reset,
  sparse_mask_walk_scheduler_if.slave bus,
  output logic o_busy
);
  typedef enum logic {
    S_IDLE,
    S_WALK
  } state_t;

  state_t                r_state;
  logic [MASK_WIDTH-1:0] r_rem_mask;
  logic [IDX_WIDTH-1:0]  r_prev_pos;
  logic                  r_out_valid;
  logic [IDX_WIDTH-1:0]  r_out_index;
  logic [IDX_WIDTH-1:0]  r_out_zero_run;
  logic [TAG_WIDTH-1:0]  r_out_tag;
  logic                  r_out_last;
  logic                  r_out_empty;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_fire;
  logic                  w_load;
  logic [MASK_WIDTH-1:0] w_enc_mask;
  logic [MASK_WIDTH-1:0] w_clr_mask;
  logic [IDX_WIDTH-1:0]  w_enc_prev;
  logic [IDX_WIDTH-1:0]  w_p;
  logic [IDX_WIDTH-1:0]  w_run;
  logic                  w_found;
  logic                  w_last;

  assign w_fire = r_out_valid & bus.out_ready;

`ifdef SPARSE_MASK_WALK_B2B_EN
  assign w_in_ready = (r_state == S_IDLE) |
                      ((r_state == S_WALK) & w_fire & r_out_last);
`else
  assign w_in_ready = (r_state == S_IDLE);
`endif

  assign w_accept = bus.in_valid & w_in_ready;
  assign w_load   = w_accept | (w_fire & ~r_out_last);

  // rem_mask and prev_pos already describe the state after the shown beat
  always_comb begin
    w_enc_mask = w_accept ? bus.in_mask : r_rem_mask;
    w_enc_prev = w_accept ? '0 : r_prev_pos;
    w_clr_mask = w_enc_mask;
    w_p        = IDX_WIDTH'(MASK_WIDTH);
    w_found    = 1'b0;
    w_last     = 1'b1;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      if (w_enc_mask[i]) begin
        if (!w_found) begin
          w_p           = IDX_WIDTH'(i);
          w_clr_mask[i] = 1'b0;
        end else begin
          w_last = 1'b0;
        end
        w_found = 1'b1;
      end
    end
  end

  assign w_run = w_p - w_enc_prev;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_rem_mask     <= '0;
      r_prev_pos     <= '0;
      r_out_valid    <= 1'b0;
      r_out_index    <= '0;
      r_out_zero_run <= '0;
      r_out_tag      <= '0;
      r_out_last     <= 1'b0;
      r_out_empty    <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_valid    <= 1'b1;
        r_out_index    <= w_p;
        r_out_zero_run <= w_run;
        r_out_last     <= w_last;
        r_out_empty    <= ~w_found;
        r_rem_mask     <= w_clr_mask;
        r_prev_pos     <= w_p + IDX_WIDTH'(1);
      end
      if (w_accept) begin
        r_out_tag <= bus.in_tag;
        r_state   <= S_WALK;
      end else if (w_fire && r_out_last) begin
        r_out_valid <= 1'b0;
        r_state     <= S_IDLE;
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_index    = r_out_index;
  assign bus.out_zero_run = r_out_zero_run;
  assign bus.out_tag      = r_out_tag;
  assign bus.out_last     = r_out_last;
  assign bus.out_empty    = r_out_empty;
  assign o_busy           = (r_state != S_IDLE);
endmodule

// File: tb/tb_sparse_mask_walk_scheduler.sv
// Randomized bench for sparse_mask_walk_scheduler with a queue model.
// Directed cases cover sparse, empty, full, reset mid-walk, b2b.
module tb_sparse_mask_walk_scheduler;
  localparam int MW = 8;
  localparam int IW = 4;
  localparam int TW = 8;

  typedef struct {
    int idx;
    int run;
    int tag;
    bit last;
    bit empty;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_chk = 0;
  int   n_bad = 0;
  int   n_fire = 0;
  int   cyc = 0;
  int   rmode = 0;
  int   fire_cyc[$];
  beat_t q[$];
  bit   have_prev = 0;
  bit   prev_held = 0;
  logic [63:0] prev_beat;

  sparse_mask_walk_scheduler_if #(
    .MASK_WIDTH(MW), .IDX_WIDTH(IW), .TAG_WIDTH(TW)
  ) bus ();

  sparse_mask_walk_scheduler #(
    .MASK_WIDTH(MW), .IDX_WIDTH(IW), .TAG_WIDTH(TW)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus(bus.slave),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_push(input logic [MW-1:0] m, input int tag);
    int prev = 0;
    bit any = 0;
    for (int i = 0; i < MW; i++) begin
      if (m[i]) begin
        q.push_back('{idx: i, run: i - prev, tag: tag,
                      last: 0, empty: 0});
        prev = i + 1;
        any = 1;
      end
    end
    if (any) q[$].last = 1;
    else q.push_back('{idx: MW, run: MW, tag: tag, last: 1, empty: 1});
  endtask

  function automatic logic [63:0] cur_beat();
    return {36'd0, bus.out_index, bus.out_zero_run, bus.out_tag,
            bus.out_last, bus.out_empty, 2'b00};
  endfunction

  always @(posedge clk) begin
    #1;
    case (rmode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = ~bus.out_ready;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    beat_t e;
    bit exp_rdy;
    cyc++;
    if (rst) begin
      q.delete();
      have_prev = 0;
      prev_held = 0;
    end else begin
      chk("valid", bus.out_valid, q.size() != 0);
      chk("busy", busy, q.size() != 0);
      exp_rdy = (q.size() == 0);
`ifdef SPARSE_MASK_WALK_B2B_EN
      if (q.size() != 0 && bus.out_valid && bus.out_ready && q[0].last)
        exp_rdy = 1;
`endif
      chk("in_ready", bus.in_ready, exp_rdy);
      if (have_prev && prev_held) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_stable", cur_beat(), prev_beat);
      end
      if (bus.out_valid && bus.out_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("index", bus.out_index, e.idx);
        chk("run", bus.out_zero_run, e.run);
        chk("tag", bus.out_tag, e.tag);
        chk("last", bus.out_last, e.last);
        chk("empty", bus.out_empty, e.empty);
        n_fire++;
        fire_cyc.push_back(cyc);
      end
      prev_beat = cur_beat();
      prev_held = bus.out_valid && !bus.out_ready;
      have_prev = 1;
      if (bus.in_valid && bus.in_ready)
        model_push(bus.in_mask, int'(bus.in_tag));
    end
  end

  task automatic send(input logic [MW-1:0] m, input logic [TW-1:0] t);
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.in_mask  = m;
    bus.in_tag   = t;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.out_valid) begin
        done = 1;
        break;
      end
    end
    chk("drain", done, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n0;
    int g;
    bit ok;
    logic [MW-1:0] m;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_mask = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fields", cur_beat(), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    rmode = 0;
    send(8'b1001_0010, 8'h5A);
    wait_idle();
    send(8'h00, 8'h11);
    wait_idle();
    rmode = 1;
    send(8'hFF, 8'h22);
    wait_idle();

    rmode = 0;
    n0 = n_fire;
    send(8'hF0, 8'h33);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (n_fire >= n0 + 2) begin
        ok = 1;
        break;
      end
    end
    chk("midwalk_fires", ok, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    send(8'h01, 8'h44);
    wait_idle();

    n0 = fire_cyc.size();
    send(8'h80, 8'h55);
    send(8'h01, 8'h66);
    wait_idle();
    if (fire_cyc.size() >= n0 + 2) begin
`ifdef SPARSE_MASK_WALK_B2B_EN
      chk("b2b_gap", fire_cyc[n0+1] - fire_cyc[n0], 1);
`else
      chk("b2b_gap", fire_cyc[n0+1] - fire_cyc[n0], 2);
`endif
    end else begin
      chk("b2b_beats", fire_cyc.size() - n0, 2);
    end

    for (int t = 0; t < 80; t++) begin
      rmode = $urandom_range(0, 2);
      case ($urandom_range(0, 5))
        0: m = '0;
        1: m = '1;
        2: m = MW'(1) << $urandom_range(0, MW - 1);
        default: m = MW'($urandom);
      endcase
      send(m, TW'($urandom));
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 7) == 0) wait_idle();
    end
    rmode = 0;
    wait_idle();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
